// File: rtl/vespa_periph_bus_master.sv
// Single-beat peripheral bus initiator: decodes one CPU access at a time to a slave
// enable plus local word index, waits the fixed slave latency and acknowledges the CPU.
module vespa_periph_bus_master #(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          SPAN_LOG2  = 8,
    parameter int          RESP_LAT   = 1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Req,
    input  logic                     i_We,
    input  logic [31:0]              i_Addr,
    input  logic [31:0]              i_WData,
    output logic                     o_Ack,
    output logic [31:0]              o_RData,
    output logic                     o_Err,
    output logic                     o_Busy,
    output logic [NUM_SLAVES-1:0]    o_WEnable,
    output logic [NUM_SLAVES-1:0]    o_REnable,
    output logic [31:0]              o_WAddr,
    output logic [31:0]              o_RAddr,
    output logic [31:0]              o_WData,
    input  logic [NUM_SLAVES*32-1:0] i_RData,
    input  logic [NUM_SLAVES-1:0]    i_Err
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int TOP   = SPAN_LOG2 + SEL_W;
    localparam int LOC_W = SPAN_LOG2 - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECERR,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [NUM_SLAVES-1:0] wen_q, wen_d;
    logic [NUM_SLAVES-1:0] ren_q, ren_d;
    logic [31:0]           waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;

    // Decode is taken straight from the request so the enable can fire in the very next cycle.
    logic                  in_win;
    logic                  misaligned;
    logic [SEL_W-1:0]      req_idx;
    logic [31:0]           req_local;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic [31:0]           slave_rdata [NUM_SLAVES];

    assign in_win     = (i_Addr[31:TOP] == BASE_ADDR[31:TOP]);
    assign misaligned = |i_Addr[1:0];
    assign req_idx    = i_Addr[TOP-1:SPAN_LOG2];
    assign req_local  = {{(32-LOC_W){1'b0}}, i_Addr[SPAN_LOG2-1:2]};

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign req_onehot[gi]  = (req_idx == SEL_W'(gi));
            assign slave_rdata[gi] = i_RData[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        wen_d   = '0;
        ren_d   = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_Req) begin
                    we_d    = i_We;
                    idx_d   = req_idx;
                    waddr_d = req_local;
                    wdata_d = i_WData;
                    if (!in_win || misaligned) begin
                        state_d = S_DECERR;
                    end else begin
                        state_d = S_ISSUE;
                        if (i_We) begin
                            wen_d = req_onehot;
                        end else begin
                            ren_d = req_onehot;
                        end
                    end
                end
            end
            S_DECERR: begin
                err_d   = 1'b1;
                ack_d   = 1'b1;
                state_d = S_RESP;
            end
            S_ISSUE: begin
                cnt_d   = 3'(RESP_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    err_d = i_Err[idx_q];
                    if (!we_q) begin
                        rdata_d = slave_rdata[idx_q];
                    end
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= '0;
            ren_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_Ack     = ack_q;
    assign o_RData   = rdata_q;
    assign o_Err     = err_q;
    assign o_Busy    = (state_q != S_IDLE);
    assign o_WEnable = wen_q;
    assign o_REnable = ren_q;
    assign o_WAddr   = waddr_q;
    assign o_RAddr   = waddr_q;
    assign o_WData   = wdata_q;

endmodule

// File: tb/tb_vespa_periph_bus_master.sv
// Bench for vespa_periph_bus_master: two instances (RESP_LAT 1 and 2) share one stimulus,
// a cycle-counting transaction model is checked every cycle, plus literal per-access checks.
module tb_vespa_periph_bus_master;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [127:0]  rdata_in = '0;
    logic [3:0]    err_in = '0;

    logic          ack    [2];
    logic [31:0]   rd_o   [2];
    logic          err_o  [2];
    logic          busy   [2];
    logic [3:0]    wen    [2];
    logic [3:0]    ren    [2];
    logic [31:0]   waddr  [2];
    logic [31:0]   raddr  [2];
    logic [31:0]   wdo    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vespa_periph_bus_master #(.RESP_LAT(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_We(we), .i_Addr(addr), .i_WData(wdata),
        .o_Ack(ack[0]), .o_RData(rd_o[0]), .o_Err(err_o[0]), .o_Busy(busy[0]),
        .o_WEnable(wen[0]), .o_REnable(ren[0]), .o_WAddr(waddr[0]), .o_RAddr(raddr[0]),
        .o_WData(wdo[0]), .i_RData(rdata_in), .i_Err(err_in)
    );

    vespa_periph_bus_master #(.RESP_LAT(2)) dut2 (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_We(we), .i_Addr(addr), .i_WData(wdata),
        .o_Ack(ack[1]), .o_RData(rd_o[1]), .o_Err(err_o[1]), .o_Busy(busy[1]),
        .o_WEnable(wen[1]), .o_REnable(ren[1]), .o_WAddr(waddr[1]), .o_RAddr(raddr[1]),
        .o_WData(wdo[1]), .i_RData(rdata_in), .i_Err(err_in)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction model: each access is a start cycle plus an end cycle derived from the latency.
    int          lat [2] = '{1, 2};
    bit          m_active [2];
    int          m_t [2];
    int          m_end [2];
    bit          m_we [2];
    int          m_idx [2];
    bit          m_bad [2];
    logic        e_ack [2];
    logic [31:0] e_rdata [2];
    logic        e_err [2];
    logic        e_busy [2];
    logic [3:0]  e_wen [2];
    logic [3:0]  e_ren [2];
    logic [31:0] e_waddr [2];
    logic [31:0] e_wdata [2];
    bit          started = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_active[m] = 1'b0;
                e_ack[m] = 1'b0; e_rdata[m] = '0; e_err[m] = 1'b0; e_busy[m] = 1'b0;
                e_wen[m] = '0; e_ren[m] = '0; e_waddr[m] = '0; e_wdata[m] = '0;
            end else if (!m_active[m]) begin
                e_ack[m] = 1'b0; e_busy[m] = 1'b0; e_wen[m] = '0; e_ren[m] = '0;
                if (req) begin
                    m_active[m] = 1'b1;
                    m_t[m]      = 1;
                    m_we[m]     = we;
                    m_idx[m]    = int'((addr >> 8) & 32'h3);
                    m_bad[m]    = ((addr & 32'hFFFF_FC00) != 32'h8000_0000) || ((addr % 4) != 0);
                    m_end[m]    = m_bad[m] ? 2 : 2 + lat[m];
                    e_waddr[m]  = (addr >> 2) & 32'h3F;
                    e_wdata[m]  = wdata;
                    e_busy[m]   = 1'b1;
                    if (!m_bad[m]) begin
                        if (we) e_wen[m] = 4'(1 << m_idx[m]);
                        else    e_ren[m] = 4'(1 << m_idx[m]);
                    end
                end
            end else begin
                if (m_t[m] == m_end[m] - 1) begin
                    if (m_bad[m]) begin
                        e_err[m] = 1'b1;
                    end else begin
                        e_err[m] = err_in[m_idx[m]];
                        if (!m_we[m]) e_rdata[m] = rdata_in[32*m_idx[m] +: 32];
                    end
                end
                m_t[m]++;
                e_wen[m]  = '0;
                e_ren[m]  = '0;
                e_ack[m]  = (m_t[m] == m_end[m]);
                e_busy[m] = (m_t[m] <= m_end[m]);
                if (m_t[m] > m_end[m]) m_active[m] = 1'b0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("c%0d d%0d ack", cyc, m),   32'(ack[m]),   32'(e_ack[m]));
                chk($sformatf("c%0d d%0d rdata", cyc, m), rd_o[m],       e_rdata[m]);
                chk($sformatf("c%0d d%0d err", cyc, m),   32'(err_o[m]), 32'(e_err[m]));
                chk($sformatf("c%0d d%0d busy", cyc, m),  32'(busy[m]),  32'(e_busy[m]));
                chk($sformatf("c%0d d%0d wen", cyc, m),   32'(wen[m]),   32'(e_wen[m]));
                chk($sformatf("c%0d d%0d ren", cyc, m),   32'(ren[m]),   32'(e_ren[m]));
                chk($sformatf("c%0d d%0d waddr", cyc, m), waddr[m],      e_waddr[m]);
                chk($sformatf("c%0d d%0d raddr", cyc, m), raddr[m],      e_waddr[m]);
                chk($sformatf("c%0d d%0d wdata", cyc, m), wdo[m],        e_wdata[m]);
                chk($sformatf("c%0d d%0d onehot", cyc, m),
                    32'($countones({wen[m], ren[m]}) <= 1), 32'd1);
            end
        end
    end

    // Slave k sees the per-cycle word with k in the top byte so each slave's data is distinct.
    function automatic logic [127:0] spread(input logic [31:0] x);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = x ^ (32'(k) << 24);
        return r;
    endfunction

    task automatic xact(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] e, input logic [4:0][31:0] v, input bit extra,
                        input int ack1, input int ack2, input logic [3:0] exp_en,
                        input logic [1:0][31:0] exp_rd, input logic exp_err);
        int          ack_n [2];
        int          ack_at [2];
        int          en_n [2];
        int          en_at [2];
        logic [3:0]  en_seen [2];
        logic [31:0] rd_ack [2];
        logic        err_ack [2];
        int          exp_ack [2];
        exp_ack[0] = ack1;
        exp_ack[1] = ack2;
        for (int m = 0; m < 2; m++) begin
            ack_n[m] = 0; ack_at[m] = 0; en_n[m] = 0; en_at[m] = 0;
            en_seen[m] = '0; rd_ack[m] = '0; err_ack[m] = 1'b0;
        end
        req = 1'b1; we = w; addr = a; wdata = d; err_in = e; rdata_in = spread(v[0]);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (ack[m]) begin
                    ack_n[m]++; ack_at[m] = j; rd_ack[m] = rd_o[m]; err_ack[m] = err_o[m];
                end
                if ((wen[m] | ren[m]) != 4'b0) begin
                    en_n[m]++; en_at[m] = j; en_seen[m] = wen[m] | ren[m];
                end
            end
            req = (extra && j == 2);
            rdata_in = spread((j < 5) ? v[j] : 32'h0);
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s d%0d ack_count", nm, m), 32'(ack_n[m]), 32'd1);
            chk($sformatf("%s d%0d ack_cycle", nm, m), 32'(ack_at[m]), 32'(exp_ack[m]));
            chk($sformatf("%s d%0d en_count", nm, m), 32'(en_n[m]), (exp_en != 4'b0) ? 32'd1 : 32'd0);
            chk($sformatf("%s d%0d en_vec", nm, m), 32'(en_seen[m]), 32'(exp_en));
            if (exp_en != 4'b0) chk($sformatf("%s d%0d en_cycle", nm, m), 32'(en_at[m]), 32'd1);
            chk($sformatf("%s d%0d rdata", nm, m), rd_ack[m], exp_rd[m]);
            chk($sformatf("%s d%0d err", nm, m), 32'(err_ack[m]), 32'(exp_err));
        end
        $display("xact %-10s addr=%h we=%0d ack@%0d/%0d rdata=%h/%h err=%0d/%0d",
                 nm, a, w, ack_at[0], ack_at[1], rd_ack[0], rd_ack[1], err_ack[0], err_ack[1]);
    endtask

    initial begin
        int late_acks;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset d%0d busy", m),  32'(busy[m]), 32'd0);
            chk($sformatf("reset d%0d rdata", m), rd_o[m], 32'd0);
            chk($sformatf("reset d%0d waddr", m), waddr[m], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        xact("outwin",   1'b0, 32'h4000_0000, 32'h0, 4'b0,
             {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 2, 2, 4'b0000,
             {32'h0, 32'h0}, 1'b1);
        xact("wr_s1",    1'b1, 32'h8000_0104, 32'h1234, 4'b0,
             {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 3, 4, 4'b0010,
             {32'h0, 32'h0}, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("wr_s1 d%0d waddr", m), waddr[m], 32'd1);
            chk($sformatf("wr_s1 d%0d wdata", m), wdo[m], 32'h1234);
        end
        xact("rd_s0",    1'b0, 32'h8000_001C, 32'h0, 4'b0,
             {32'h4444, 32'h3333, 32'hCAFE, 32'h2222, 32'h1111}, 1'b0, 3, 4, 4'b0001,
             {32'h0000_3333, 32'h0000_CAFE}, 1'b0);
        for (int m = 0; m < 2; m++) chk($sformatf("rd_s0 d%0d waddr", m), waddr[m], 32'd7);
        xact("rd_s2_err", 1'b0, 32'h8000_0220, 32'h0, 4'b0100,
             {32'h50, 32'h40, 32'h30, 32'h20, 32'h10}, 1'b1, 3, 4, 4'b0100,
             {32'h0200_0040, 32'h0200_0030}, 1'b1);
        xact("rd_s3",    1'b0, 32'h8000_0300, 32'h0, 4'b0,
             {32'h500, 32'h400, 32'h300, 32'h200, 32'h100}, 1'b0, 3, 4, 4'b1000,
             {32'h0300_0400, 32'h0300_0300}, 1'b0);
        xact("misalign", 1'b1, 32'h8000_0002, 32'hBEEF, 4'b0,
             {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 2, 2, 4'b0000,
             {32'h0300_0400, 32'h0300_0300}, 1'b1);

        // Reset lands while both instances sit in WAIT.
        req = 1'b1; we = 1'b0; addr = 32'h8000_0004; err_in = 4'b0; rdata_in = spread(32'h77);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_wait d%0d busy", m),  32'(busy[m]), 32'd0);
            chk($sformatf("rst_wait d%0d ack", m),   32'(ack[m]), 32'd0);
            chk($sformatf("rst_wait d%0d waddr", m), waddr[m], 32'd0);
            chk($sformatf("rst_wait d%0d ren", m),   32'(ren[m]), 32'd0);
        end
        rst = 1'b0;
        late_acks = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (ack[0] || ack[1]) late_acks++;
        end
        chk("rst_wait no_ack", 32'(late_acks), 32'd0);
        $display("xact %-10s addr=%h reset during WAIT, late acks=%0d", "rst_wait", 32'h8000_0004, late_acks);

        xact("rd_after",  1'b0, 32'h8000_001C, 32'h0, 4'b0,
             {32'h4444, 32'h3333, 32'hCAFE, 32'h2222, 32'h1111}, 1'b0, 3, 4, 4'b0001,
             {32'h0000_3333, 32'h0000_CAFE}, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
